rank_mr_sequencer: RTL

- Sits directly downstream of apb_slave_port and consumes its per-rank rank_mrw_o/rank_mrr_o request levels.
- Arbitrates the requests round-robin and issues one mode-register command at a time on a DRAM-side command/response handshake.
- Times completion and returns single-cycle done pulses that drive the slave's mrw_done_status_i/mrr_done_status_i. Those pulses in turn raise the slave's rank interrupt.

---
 rtl/rank_mr_pkg.sv | 21 ++
 rtl/rank_rr_arbiter.sv | 26 ++
 rtl/rank_mr_sequencer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/rank_mr_pkg.sv
// Shared types and constants for the rank mode-register sequencer.
// Holds the sequencer state encoding, the command type encoding and the rank index width helper.
package rank_mr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WR_WAIT,
    RD_WAIT,
    DONE
  } state_t;

  localparam logic CMD_MRW = 1'b0;
  localparam logic CMD_MRR = 1'b1;

  // A single-rank configuration still needs a one-bit rank field.
  function automatic int rank_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rank_rr_arbiter.sv
// Combinational round-robin pick: returns the first requesting rank at or after ptr, wrapping.
module rank_rr_arbiter #(
  parameter int NB_RANK = 8,
  parameter int IW      = 3
) (
  input  logic [NB_RANK-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [IW-1:0]      gnt_idx,
  output logic               gnt_valid
);

  always_comb begin
    int idx;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int i = 0; i < NB_RANK; i++) begin
      idx = (int'(ptr) + i) % NB_RANK;
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/rank_mr_sequencer.sv
// Round-robin mode-register sequencer: issues one MRW/MRR at a time to the DRAM side
// and returns per-rank single-cycle done pulses to the APB slave.
module rank_mr_sequencer
  import rank_mr_pkg::*;
#(
  parameter int NB_RANK     = 8,
  parameter int MR_AW       = 8,
  parameter int MR_DW       = 8,
  parameter int T_MRD       = 4,
  parameter int MRR_TIMEOUT = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NB_RANK-1:0]              rank_mrw_i,
  input  logic [NB_RANK-1:0]              rank_mrr_i,
  input  logic [NB_RANK*MR_AW-1:0]        mr_addr_i,
  input  logic [NB_RANK*MR_DW-1:0]        mr_wdata_i,
  output logic                            cmd_valid_o,
  input  logic                            cmd_ready_i,
  output logic [rank_idx_w(NB_RANK)-1:0]  cmd_rank_o,
  output logic                            cmd_read_o,
  output logic [MR_AW-1:0]                cmd_addr_o,
  output logic [MR_DW-1:0]                cmd_wdata_o,
  input  logic                            rsp_valid_i,
  input  logic [MR_DW-1:0]                rsp_data_i,
  output logic [NB_RANK-1:0]              mrw_done_status_o,
  output logic [NB_RANK-1:0]              mrr_done_status_o,
  output logic [MR_DW-1:0]                mrr_rdata_o,
  output logic                            mrr_err_o
);

  localparam int RW     = rank_idx_w(NB_RANK);
  localparam int CNT_MX = (T_MRD > MRR_TIMEOUT) ? T_MRD : MRR_TIMEOUT;
  localparam int CW     = $clog2(CNT_MX + 1);

  state_t state, state_nxt;

  logic [NB_RANK-1:0] served_w, served_r;
  logic [NB_RANK-1:0] elig_w, elig_r, elig_any;
  logic [NB_RANK-1:0] rank_onehot, set_w, set_r;
  logic [RW-1:0]      rr_ptr, gnt_idx, lat_rank;
  logic               gnt_valid;
  logic               lat_read, err_flag;
  logic [MR_AW-1:0]   lat_addr;
  logic [MR_DW-1:0]   lat_wdata, rdata_q;
  logic [CW-1:0]      cnt;

  // A level that has already been serviced stays ineligible until it is seen low.
  assign elig_w   = rank_mrw_i & ~served_w;
  assign elig_r   = rank_mrr_i & ~served_r;
  assign elig_any = elig_w | elig_r;

  rank_rr_arbiter #(
    .NB_RANK (NB_RANK),
    .IW      (RW)
  ) u_arb (
    .req       (elig_any),
    .ptr       (rr_ptr),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  assign rank_onehot = NB_RANK'(1) << lat_rank;
  assign set_w = (state == DONE && lat_read == CMD_MRW) ? rank_onehot : '0;
  assign set_r = (state == DONE && lat_read == CMD_MRR) ? rank_onehot : '0;

  assign cmd_valid_o       = (state == CMD);
  assign cmd_rank_o        = lat_rank;
  assign cmd_read_o        = lat_read;
  assign cmd_addr_o        = lat_addr;
  assign cmd_wdata_o       = lat_wdata;
  assign mrw_done_status_o = set_w;
  assign mrr_done_status_o = set_r;
  assign mrr_rdata_o       = rdata_q;
  assign mrr_err_o         = (state == DONE) && err_flag;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (gnt_valid) state_nxt = CMD;
      CMD:     if (cmd_ready_i) state_nxt = (lat_read == CMD_MRR) ? RD_WAIT : WR_WAIT;
      WR_WAIT: if (cnt == '0) state_nxt = DONE;
      RD_WAIT: if (rsp_valid_i || cnt == CW'(MRR_TIMEOUT)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: grant latching, wait counters, read data capture and round-robin bookkeeping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      served_w  <= '0;
      served_r  <= '0;
      rr_ptr    <= '0;
      lat_rank  <= '0;
      lat_read  <= CMD_MRW;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
      err_flag  <= 1'b0;
      cnt       <= '0;
    end else begin
      served_w <= (served_w & rank_mrw_i) | set_w;
      served_r <= (served_r & rank_mrr_i) | set_r;
      unique case (state)
        IDLE: begin
          if (gnt_valid) begin
            lat_rank  <= gnt_idx;
            lat_read  <= elig_w[gnt_idx] ? CMD_MRW : CMD_MRR;
            lat_addr  <= mr_addr_i[gnt_idx*MR_AW +: MR_AW];
            lat_wdata <= elig_w[gnt_idx] ? mr_wdata_i[gnt_idx*MR_DW +: MR_DW] : '0;
            err_flag  <= 1'b0;
          end
        end
        CMD: begin
          if (cmd_ready_i) cnt <= (lat_read == CMD_MRR) ? CW'(1) : CW'(T_MRD - 1);
        end
        WR_WAIT: begin
          if (cnt != '0) cnt <= cnt - CW'(1);
        end
        RD_WAIT: begin
          // A response on the timeout cycle wins over the timeout.
          if (rsp_valid_i) begin
            rdata_q <= rsp_data_i;
          end else if (cnt == CW'(MRR_TIMEOUT)) begin
            rdata_q  <= '0;
            err_flag <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          rr_ptr <= (int'(lat_rank) == NB_RANK - 1) ? '0 : lat_rank + RW'(1);
          cnt    <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
